// File: rtl/quokka_io_pkg.sv
// Shared types and constants for the quokka input conditioner:
// startup state encoding, default parameter values and a counter-width helper.
package quokka_io_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STARTING = 2'd1,
      STARTED  = 2'd2
   } startupState_t;

   localparam int DEFAULT_CHANNELS        = 4;
   localparam int DEFAULT_SYNC_STAGES     = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
   localparam int DEFAULT_STARTUP_CYCLES  = 4;

   // Bits needed to hold every value 0..maxValue, never less than one.
   function automatic int counterWidth(input int maxValue);
      int width;
      width = 1;
      while (width < 31 && (1 << width) <= maxValue) width++;
      return width;
   endfunction

endpackage

// File: rtl/quokka_debounce_channel.sv
// One input channel: synchroniser chain, debounce filter, qualified level and
// raw edge pulses. The startup mask on the pulses is applied by the parent.
module quokka_debounce_channel
   import quokka_io_pkg::*;
#(
   parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic RESET_BIT       = 1'b0
)(
   input  logic Clock,
   input  logic Reset,
   input  logic InternalReset,
   input  logic In,
   output logic Out,
   output logic RisePulse,
   output logic FallPulse
);

   localparam int CNT_W = counterWidth(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] syncChain;
   logic [CNT_W-1:0]       count;
   logic [CNT_W-1:0]       nextCount;
   logic                   synced;
   logic                   nextOut;

   assign synced = syncChain[SYNC_STAGES-1];

   // Shift the raw input through the synchroniser flops.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         syncChain <= {SYNC_STAGES{RESET_BIT}};
      end else if (InternalReset) begin
         syncChain <= {SYNC_STAGES{RESET_BIT}};
      end else begin
         syncChain <= {syncChain[SYNC_STAGES-2:0], In};
      end
   end

   if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // No filtering: the synchronised level passes straight through.
      always_comb begin
         nextOut   = synced;
         nextCount = '0;
      end
   end else begin : g_filter
      localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
      // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges.
      always_comb begin
         nextOut   = Out;
         nextCount = count + 1'b1;
         if (synced == Out) begin
            nextCount = '0;
         end else if (count == COUNT_LAST) begin
            nextOut   = synced;
            nextCount = '0;
         end
      end
   end

   // Register the qualified level, filter counter and the edge pulses,
   // so a pulse lines up with the first cycle Out shows the new level.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         Out       <= RESET_BIT;
         count     <= '0;
         RisePulse <= 1'b0;
         FallPulse <= 1'b0;
      end else if (InternalReset) begin
         Out       <= RESET_BIT;
         count     <= '0;
         RisePulse <= 1'b0;
         FallPulse <= 1'b0;
      end else begin
         Out       <= nextOut;
         count     <= nextCount;
         RisePulse <= nextOut & ~Out;
         FallPulse <= ~nextOut & Out;
      end
   end

endmodule

// File: rtl/quokka_input_conditioner.sv
// Multi-channel input conditioner: per-channel sync/debounce/edge detect plus
// a timed startup sequencer that gates edge strobes until startup completes.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | in reset, nothing running
// STARTING | running, waiting out STARTUP_CYCLES; edge strobes masked
// STARTED  | startup complete, edge strobes enabled (terminal)
module quokka_input_conditioner
   import quokka_io_pkg::*;
#(
   parameter int                  CHANNELS        = DEFAULT_CHANNELS,
   parameter int                  SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int                  DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic [CHANNELS-1:0] RESET_VALUE     = {CHANNELS{1'b0}},
   parameter int                  STARTUP_CYCLES  = DEFAULT_STARTUP_CYCLES
)(
   input  logic                Clock,
   input  logic                Reset,
   input  logic                InternalReset,
   input  logic [CHANNELS-1:0] In,
   output logic [CHANNELS-1:0] Out,
   output logic [CHANNELS-1:0] Rise,
   output logic [CHANNELS-1:0] Fall,
   output logic                Running,
   output logic                Starting,
   output logic                Started
);

   localparam int                 START_W    = counterWidth(STARTUP_CYCLES - 1);
   localparam logic [START_W-1:0] START_LAST = START_W'(STARTUP_CYCLES - 1);

   startupState_t      state;
   startupState_t      nextState;
   logic [START_W-1:0] startCount;
   logic [START_W-1:0] nextCount;
   logic [CHANNELS-1:0] risePulse;
   logic [CHANNELS-1:0] fallPulse;

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel
      quokka_debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_BIT       (RESET_VALUE[ch])
      ) u_channel (
         .Clock         (Clock),
         .Reset         (Reset),
         .InternalReset (InternalReset),
         .In            (In[ch]),
         .Out           (Out[ch]),
         .RisePulse     (risePulse[ch]),
         .FallPulse     (fallPulse[ch])
      );
   end

   // Startup state and window counter register.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         startCount <= '0;
      end else if (InternalReset) begin
         state      <= IDLE;
         startCount <= '0;
      end else begin
         state      <= nextState;
         startCount <= nextCount;
      end
   end

   // Next-state logic; unused encodings fall back to IDLE.
   always_comb begin
      nextState = state;
      nextCount = startCount;
      case (state)
         IDLE: begin
            nextState = STARTING;
            nextCount = '0;
         end
         STARTING: begin
            if (startCount == START_LAST) begin
               nextState = STARTED;
               nextCount = '0;
            end else begin
               nextCount = startCount + 1'b1;
            end
         end
         STARTED: begin
            nextCount = '0;
         end
         default: begin
            nextState = IDLE;
            nextCount = '0;
         end
      endcase
   end

   assign Running  = (state != IDLE);
   assign Started  = (state == STARTED);
   assign Starting = Running & ~Started;

   // Edge strobes are held off until startup has finished.
   assign Rise = risePulse & {CHANNELS{Started}};
   assign Fall = fallPulse & {CHANNELS{Started}};

endmodule

// File: tb/tb_quokka_input_conditioner.sv
// Bench for quokka_input_conditioner: two instances (filtered, and bypass with
// a non-zero reset level) against a behavioural model, plus directed pins.
module tb_quokka_input_conditioner;

   localparam int SYNC    = 2;
   localparam int STARTUP = 4;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       InternalReset = 1'b0;
   logic [3:0] In = 4'b0000;

   logic [3:0] outA, riseA, fallA, outB, riseB, fallB;
   logic       runA, startingA, startedA, runB, startingB, startedB;

   always #5 Clock = ~Clock;

   quokka_input_conditioner #(
      .CHANNELS(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(16),
      .RESET_VALUE(4'b0000), .STARTUP_CYCLES(STARTUP)
   ) dutA (
      .Clock(Clock), .Reset(Reset), .InternalReset(InternalReset), .In(In),
      .Out(outA), .Rise(riseA), .Fall(fallA),
      .Running(runA), .Starting(startingA), .Started(startedA)
   );

   quokka_input_conditioner #(
      .CHANNELS(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(0),
      .RESET_VALUE(4'b1010), .STARTUP_CYCLES(STARTUP)
   ) dutB (
      .Clock(Clock), .Reset(Reset), .InternalReset(InternalReset), .In(In),
      .Out(outB), .Rise(riseB), .Fall(fallB),
      .Running(runB), .Starting(startingB), .Started(startedB)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model. Index 0 = dutA, 1 = dutB.
   int         dbCycles[2] = '{16, 0};
   logic [3:0] rstVal[2]   = '{4'b0000, 4'b1010};
   logic [3:0] mDelay[2][SYNC];   // input samples delayed by SYNC edges
   logic [3:0] mOut[2];
   logic [3:0] mRise[2];
   logic [3:0] mFall[2];
   int         mRun[2][4];        // consecutive edges the synced level differed from Out
   int         mEdges;            // edges since reset release

   always @(posedge Clock or negedge Reset) begin
      if (!Reset || InternalReset) begin
         for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < SYNC; s++) mDelay[k][s] = rstVal[k];
            mOut[k]  = rstVal[k];
            mRise[k] = 4'b0;
            mFall[k] = 4'b0;
            for (int i = 0; i < 4; i++) mRun[k][i] = 0;
         end
         mEdges = 0;
      end else begin
         if (mEdges < 1000) mEdges = mEdges + 1;
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
               logic s, prev, nv;
               s    = mDelay[k][SYNC-1][i];
               prev = mOut[k][i];
               nv   = prev;
               if (dbCycles[k] == 0) begin
                  nv = s;
               end else if (s != prev) begin
                  mRun[k][i] = mRun[k][i] + 1;
                  if (mRun[k][i] == dbCycles[k]) begin
                     nv = s;
                     mRun[k][i] = 0;
                  end
               end else begin
                  mRun[k][i] = 0;
               end
               mRise[k][i] = !prev && nv;
               mFall[k][i] = prev && !nv;
               mOut[k][i]  = nv;
            end
            for (int s = SYNC - 1; s > 0; s--) mDelay[k][s] = mDelay[k][s-1];
            mDelay[k][0] = In;
         end
      end
   end

   bit cmpEnable = 0;

   // Every-cycle comparison against the model, 1 time unit after the edge.
   always @(posedge Clock) begin
      #1;
      if (cmpEnable) begin
         logic expRun, expStarted;
         expRun     = (mEdges >= 1);
         expStarted = (mEdges >= 1 + STARTUP);
         check("A.Out",      outA, mOut[0]);
         check("B.Out",      outB, mOut[1]);
         check("A.Rise",     riseA, expStarted ? mRise[0] : 4'b0);
         check("A.Fall",     fallA, expStarted ? mFall[0] : 4'b0);
         check("B.Rise",     riseB, expStarted ? mRise[1] : 4'b0);
         check("B.Fall",     fallB, expStarted ? mFall[1] : 4'b0);
         check("A.Running",  runA, expRun);
         check("B.Running",  runB, expRun);
         check("A.Started",  startedA, expStarted);
         check("B.Started",  startedB, expStarted);
         check("A.Starting", startingA, expRun && !expStarted);
         check("B.Starting", startingB, expRun && !expStarted);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int aRise, aHigh, bRise, bFall, bHigh;

      // Reset held 3 cycles, input opposite to dutB's reset level on some bits.
      In = 4'b0001;
      repeat (3) @(posedge Clock);
      #1;
      check("reset A.Out", outA, 4'b0000);
      check("reset B.Out", outB, 4'b1010);
      check("reset Running", runA, 1'b0);
      check("reset A.Rise", riseA, 4'b0);
      cmpEnable = 1;

      // Startup window; dutB's level moves during it but strobes stay masked.
      @(negedge Clock) Reset = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         @(posedge Clock); #1;
         check("startup Running", runA, 1'b1);
         check("startup Starting", startingA, e <= 4);
         check("startup Started", startedA, e >= 5);
         if (e == 2) check("startup B.Out hold", outB, 4'b1010);
         if (e == 3) begin
            check("startup B.Out", outB, 4'b0001);
            check("startup B.Rise", riseB, 4'b0);
            check("startup B.Fall", fallB, 4'b0);
         end
      end
      repeat (20) @(posedge Clock);

      // Clean 0->1 step on channel 2.
      @(negedge Clock) In = 4'b0101;
      for (int e = 1; e <= 19; e++) begin
         @(posedge Clock); #1;
         if (e == 3)  check("step B.Rise", riseB, 4'b0100);
         if (e == 17) check("step A.Out early", outA, 4'b0001);
         if (e == 18) begin
            check("step A.Out", outA, 4'b0101);
            check("step A.Rise", riseA, 4'b0100);
            check("step A.Fall", fallA, 4'b0000);
         end
         if (e == 19) check("step A.Rise clear", riseA, 4'b0000);
      end

      @(negedge Clock) In = 4'b0000;
      repeat (25) @(posedge Clock);

      // 10-cycle pulse on channel 0: filtered away on A, passed on B.
      aRise = 0; aHigh = 0; bRise = 0; bFall = 0; bHigh = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge Clock) In[0] = (c < 10);
         @(posedge Clock); #1;
         aRise += riseA[0];
         aHigh += outA[0];
         bRise += riseB[0];
         bFall += fallB[0];
         bHigh += outB[0];
      end
      check("glitch A.Rise count", aRise, 0);
      check("glitch A.Out high", aHigh, 0);
      check("glitch B.Rise count", bRise, 1);
      check("glitch B.Fall count", bFall, 1);
      check("glitch B.Out high", bHigh, 10);

      // Async reset part-way through a debounce (counter at 9).
      @(negedge Clock) In = 4'b1000;
      repeat (22) @(posedge Clock);
      @(negedge Clock) In = 4'b1010;
      repeat (11) @(posedge Clock);
      @(negedge Clock);
      #2 Reset = 1'b0;
      #1;
      check("async A.Out", outA, 4'b0000);
      check("async B.Out", outB, 4'b1010);
      check("async Running", runA, 1'b0);
      check("async A.Rise", riseA, 4'b0);
      check("async A.Fall", fallA, 4'b0);
      @(negedge Clock) Reset = 1'b1;
      for (int e = 1; e <= 18; e++) begin
         @(posedge Clock); #1;
         if (e == 17) check("restart A.Out early", outA, 4'b0000);
         if (e == 18) begin
            check("restart A.Out", outA, 4'b1010);
            check("restart A.Rise", riseA, 4'b1010);
         end
      end

      // Soft reset pulse while STARTED.
      repeat (3) @(posedge Clock);
      @(negedge Clock) InternalReset = 1'b1;
      @(posedge Clock); #1;
      check("soft Running", runA, 1'b0);
      check("soft Started", startedA, 1'b0);
      check("soft A.Out", outA, 4'b0000);
      check("soft B.Out", outB, 4'b1010);
      @(negedge Clock) InternalReset = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         @(posedge Clock); #1;
         check("soft restart Starting", startingA, e <= 4);
         check("soft restart Started", startedA, e >= 5);
      end

      // Randomized traffic with occasional soft and async resets.
      for (int cyc = 0; cyc < 1500; cyc++) begin
         int rate;
         rate = ((cyc / 300) % 2 == 1) ? 11 : 39;
         @(negedge Clock);
         for (int ch = 0; ch < 4; ch++)
            if ($urandom_range(0, rate) == 0) In[ch] = ~In[ch];
         InternalReset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 399) == 0) begin
            #($urandom_range(1, 3));
            Reset = 1'b0;
            @(negedge Clock);
            Reset = 1'b1;
         end
      end
      @(negedge Clock) InternalReset = 1'b0;
      repeat (3) @(posedge Clock);
      #2;
      cmpEnable = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/quokka_input_conditioner.md
Name: quokka_input_conditioner

Overview:
- Multi-channel successor to the board-signal and two-flop synchroniser pair: generic sync depth, per-channel debounce, edge pulses and a timed startup sequencer.
- Sits between raw board inputs (buttons, switches, async status lines) and the logic RAM / core, in the board clock domain.
- Provides qualified levels, one-cycle edge strobes and Running/Starting/Started status.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles before Out changes; 0 = bypass
RESET_VALUE, {CHANNELS{1'b0}}, per-channel reset level for sync chain and Out
STARTUP_CYCLES, 4, cycles spent in STARTING before STARTED (>=1)

Ports:
Clock  in  1  single system clock
Reset  in  1  asynchronous, active-low reset (0 = reset asserted)
InternalReset  in  1  synchronous active-high soft reset, same effect as Reset at next edge
In  in  CHANNELS  raw asynchronous inputs
Out  out  CHANNELS  synchronised, debounced levels
Rise  out  CHANNELS  one-cycle pulse when Out goes 0->1
Fall  out  CHANNELS  one-cycle pulse when Out goes 1->0
Running  out  1  high from first cycle after reset release
Starting  out  1  Running & !Started
Started  out  1  startup window complete

Behaviour:
- Reset values: sync chain and Out = RESET_VALUE; Rise = Fall = 0; debounce counters = 0; FSM = IDLE, so Running = Starting = Started = 0.
- Reset assertion mid-operation forces these values immediately, with no clock needed. Release is sampled on Clock.
- InternalReset = 1 at an edge loads the same values. It has priority over all other updates.
- Sync: In[i] shifts through SYNC_STAGES flops. The last stage is synced[i]. Every stage resets to RESET_VALUE[i].
- Debounce per channel, counter width clog2(DEBOUNCE_CYCLES+1), evaluated at each edge:
  - synced == Out: cnt <= 0.
  - synced != Out and cnt == DEBOUNCE_CYCLES-1: Out <= synced; cnt <= 0.
  - otherwise: cnt <= cnt+1.
- DEBOUNCE_CYCLES = 0: Out <= synced every edge.
- Latency: a clean In step stable before edge 0 appears on Out after edge SYNC_STAGES+max(DEBOUNCE_CYCLES,1).
- Glitch shorter than DEBOUNCE_CYCLES synced cycles: no Out change, counter returns to 0.
- Rise[i]/Fall[i] are registered and asserted in the same cycle Out[i] first shows the new value, for exactly one cycle.
- Rise/Fall are masked (forced 0) while Started = 0. Out still tracks the input during startup.
- Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses.
- Startup FSM:
  - IDLE -> STARTING on first edge with Reset high and InternalReset low.
  - STARTING holds for STARTUP_CYCLES cycles (counter 0..STARTUP_CYCLES-1), then -> STARTED.
  - STARTED is terminal until reset.
- FSM outputs: Running = (state != IDLE); Started = (state == STARTED); Starting = Running & !Started.
- No illegal-state lockup: unused encodings go to IDLE.

Decomposition:
- Package quokka_io_pkg: startup state enum (IDLE, STARTING, STARTED), clog2 width function, default parameter constants.
- Sub-module quokka_debounce_channel: sync chain, counter, Out, Rise/Fall for one bit; generate-instantiated CHANNELS times.
- Top holds the FSM and the Started mask.

Test Plan:
- Reset low 3 cycles then high, STARTUP_CYCLES=4 -> Running=1 after edge 1; Starting=1 for 4 cycles; Started=1 from edge 5 onward.
- CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=16, after Started: In[2] 0->1 held -> Out[2]=1 after edge 18; Rise[2]=1 exactly that cycle; other outputs unchanged.
- DEBOUNCE_CYCLES=16: In[0] pulsed high 10 cycles -> Out[0] stays 0, no Rise. Same input with DEBOUNCE_CYCLES=0 -> Out[0] high for 10 cycles, Rise and Fall pulses.
- In toggled before Started, RESET_VALUE=4'b1010 -> Out tracks with the same latency; Rise/Fall stay 0; Out=4'b1010 after reset.
- Reset driven low asynchronously mid-debounce (cnt=9) -> Out, Rise, Fall, Running cleared immediately. After release, full debounce restarts from cnt=0.
- InternalReset pulsed 1 cycle in STARTED -> next edge everything returns to reset values; FSM re-runs STARTING for STARTUP_CYCLES cycles.
